// File: rtl/tpu_sequencer.sv
// Tile sequencer for the 32x32 TPU: weight load, UB stream, pipeline drain, result write.
// Outputs are registered from the next-state values so each phase shows up in the cycle it starts.
module tpu_sequencer #(
    parameter int ADDRESSSIZE      = 10,
    parameter int ADDRESSSIZE_fifo = 2,
    parameter int MATRIX_SIZE      = 32,
    parameter int WLOAD_CYC        = 2,
    parameter int PIPE_LAT         = 95
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDRESSSIZE-1:0]        ub_base,
    input  logic [ADDRESSSIZE-1:0]        res_base,
    input  logic [ADDRESSSIZE_fifo-1:0]   weight_sel,
    input  logic [$clog2(MATRIX_SIZE):0]  num_rows,
    output logic [ADDRESSSIZE-1:0]        ub_address,
    output logic                          ub_read_valid,
    output logic [ADDRESSSIZE_fifo-1:0]   wsram_address,
    output logic                          we_rl,
    output logic                          res_write_enable,
    output logic [ADDRESSSIZE-1:0]        res_address,
    output logic                          busy,
    output logic                          done
);
    localparam int RW = $clog2(MATRIX_SIZE) + 1;
    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam int WW = $clog2(WLOAD_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_STREAM, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t                       r_state, w_nstate;
    logic [RW-1:0]                r_row, w_nrow;
    logic [DW-1:0]                r_drn, w_ndrn;
    logic [WW-1:0]                r_wl, w_nwl;
    logic [ADDRESSSIZE-1:0]       r_ub_base, r_res_base;
    logic [ADDRESSSIZE_fifo-1:0]  r_wsel;
    logic [RW-1:0]                r_n;
    logic [RW-1:0]                w_clamp;
    logic                         w_take;
    logic [ADDRESSSIZE_fifo-1:0]  w_wsel;
    logic                         w_last_row;

    assign w_clamp    = (num_rows == '0 || num_rows > RW'(MATRIX_SIZE)) ? RW'(MATRIX_SIZE) : num_rows;
    assign w_take     = (r_state == S_IDLE) && start && !abort;
    // First WLOAD cycle is driven before the capture register is loaded.
    assign w_wsel     = w_take ? weight_sel : r_wsel;
    assign w_last_row = (r_row == r_n - RW'(1));

    always_comb begin
        w_nstate = r_state;
        w_nrow   = r_row;
        w_ndrn   = r_drn;
        w_nwl    = r_wl;
        if (abort) begin
            w_nstate = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_nstate = S_WLOAD;
                S_WLOAD:  if (r_wl == WW'(WLOAD_CYC - 1)) w_nstate = S_STREAM;
                          else w_nwl = r_wl + WW'(1);
                S_STREAM: if (w_last_row) w_nstate = S_DRAIN;
                          else w_nrow = r_row + RW'(1);
                S_DRAIN:  if (r_drn == DW'(PIPE_LAT - 1)) w_nstate = S_WRITE;
                          else w_ndrn = r_drn + DW'(1);
                S_WRITE:  if (w_last_row) w_nstate = S_DONE;
                          else w_nrow = r_row + RW'(1);
                S_DONE:   w_nstate = S_IDLE;
                default:  w_nstate = S_IDLE;
            endcase
        end
        // Every state entry starts its counters from zero.
        if (w_nstate != r_state) begin
            w_nrow = '0;
            w_ndrn = '0;
            w_nwl  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_row            <= '0;
            r_drn            <= '0;
            r_wl             <= '0;
            r_ub_base        <= '0;
            r_res_base       <= '0;
            r_wsel           <= '0;
            r_n              <= RW'(MATRIX_SIZE);
            ub_address       <= '0;
            ub_read_valid    <= 1'b0;
            wsram_address    <= '0;
            we_rl            <= 1'b0;
            res_write_enable <= 1'b0;
            res_address      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_row   <= w_nrow;
            r_drn   <= w_ndrn;
            r_wl    <= w_nwl;
            if (w_take) begin
                r_ub_base  <= ub_base;
                r_res_base <= res_base;
                r_wsel     <= weight_sel;
                r_n        <= w_clamp;
            end
            ub_read_valid    <= (w_nstate == S_STREAM);
            ub_address       <= (w_nstate == S_STREAM) ? r_ub_base + ADDRESSSIZE'(w_nrow) : '0;
            wsram_address    <= (w_nstate == S_WLOAD) ? w_wsel : '0;
            we_rl            <= (w_nstate == S_WLOAD) && (w_nwl == WW'(WLOAD_CYC - 1));
            res_write_enable <= (w_nstate == S_WRITE);
            res_address      <= (w_nstate == S_WRITE) ? r_res_base + ADDRESSSIZE'(w_nrow) : '0;
            busy             <= (w_nstate == S_WLOAD) || (w_nstate == S_STREAM) ||
                                (w_nstate == S_DRAIN) || (w_nstate == S_WRITE);
            done             <= (w_nstate == S_DONE);
        end
    end
endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: tile table, corner-case sequences and random traffic,
// all checked every cycle against a timeline model of the tile phases.
module tb_tpu_sequencer;
    localparam int AS = 10;
    localparam int AF = 2;
    localparam int MS = 32;
    localparam int WL = 2;
    localparam int PL = 95;
    localparam int RW = $clog2(MS) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0;
    logic [AS-1:0] ub_base = '0, res_base = '0;
    logic [AF-1:0] weight_sel = '0;
    logic [RW-1:0] num_rows = '0;
    logic [AS-1:0] ub_address, res_address;
    logic          ub_read_valid, we_rl, res_write_enable, busy, done;
    logic [AF-1:0] wsram_address;

    tpu_sequencer #(.ADDRESSSIZE(AS), .ADDRESSSIZE_fifo(AF), .MATRIX_SIZE(MS),
                    .WLOAD_CYC(WL), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ub_base(ub_base), .res_base(res_base), .weight_sel(weight_sel), .num_rows(num_rows),
        .ub_address(ub_address), .ub_read_valid(ub_read_valid), .wsram_address(wsram_address),
        .we_rl(we_rl), .res_write_enable(res_write_enable), .res_address(res_address),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int ecnt = 0, done_cnt = 0, done_e = -1;

    // Model: a tile is just its start edge plus captured parameters; the phase is
    // read off the period index c (c = 1 is the first cycle after the start edge).
    bit            m_act = 1'b0;
    int            m_s = 0, m_n = MS;
    logic [AS-1:0] m_ub = '0, m_res = '0;
    logic [AF-1:0] m_ws = '0;

    function automatic int tile_len(int n);
        return WL + 2 * n + PL + 1;
    endfunction

    function automatic logic [26:0] model_out();
        logic [AS-1:0] ua = '0, ra = '0;
        logic [AF-1:0] w = '0;
        logic uv = 0, we = 0, rwe = 0, b = 0, d = 0;
        int c;
        c = ecnt - m_s + 1;
        if (m_act && c >= 1) begin
            if (c <= WL) begin
                w = m_ws; we = (c == WL); b = 1;
            end else if (c <= WL + m_n) begin
                uv = 1; ua = m_ub + AS'(c - WL - 1); b = 1;
            end else if (c <= WL + m_n + PL) begin
                b = 1;
            end else if (c <= WL + 2 * m_n + PL) begin
                rwe = 1; ra = m_res + AS'(c - WL - m_n - PL - 1); b = 1;
            end else if (c == tile_len(m_n)) begin
                d = 1;
            end
        end
        return {ua, uv, w, we, rwe, ra, b, d};
    endfunction

    function automatic logic [26:0] dut_out();
        return {ub_address, ub_read_valid, wsram_address, we_rl, res_write_enable,
                res_address, busy, done};
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, ecnt, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        int nr;
        @(posedge clk);
        #1;
        ecnt++;
        if (rst) begin
            m_act = 0;
        end else if (abort) begin
            m_act = 0;
        end else if (start && (!m_act || (ecnt - m_s) > tile_len(m_n))) begin
            nr    = int'(num_rows);
            m_act = 1;
            m_s   = ecnt;
            m_ub  = ub_base;
            m_res = res_base;
            m_ws  = weight_sel;
            m_n   = (nr == 0 || nr > MS) ? MS : nr;
        end
        check("cycle", dut_out(), model_out());
        if (done) begin
            done_cnt++;
            done_e = ecnt;
        end
    endtask

    task automatic wait_done(output int e);
        for (int k = 0; k < 400 && done_e < 0; k++) step();
        if (done_e < 0) begin
            fails++;
            $display("FAIL done_timeout got=none want=done");
        end
        e = done_e;
    endtask

    task automatic launch(input logic [AS-1:0] ub, input logic [AS-1:0] rb,
                          input logic [AF-1:0] ws, input logic [RW-1:0] nr, output int s0);
        ub_base = ub; res_base = rb; weight_sel = ws; num_rows = nr;
        done_e = -1;
        start = 1;
        step();
        s0 = ecnt;
        start = 0;
    endtask

    typedef struct {
        logic [AS-1:0] ub;
        logic [AS-1:0] rb;
        logic [AF-1:0] ws;
        logic [RW-1:0] nr;
        int            lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int s0, s1, e, dc0, d1, d2;
        tbl[0] = '{10'h010, 10'h000, 2'd2, 6'd32, 162};
        tbl[1] = '{10'h3FE, 10'h3FF, 2'd1, 6'd4,  106};
        tbl[2] = '{10'h123, 10'h200, 2'd3, 6'd0,  162};
        tbl[3] = '{10'h3F0, 10'h3E0, 2'd0, 6'd40, 162};
        tbl[4] = '{10'h055, 10'h3FF, 2'd1, 6'd1,  100};

        step();
        step();
        check("reset_state", dut_out(), 27'd0);
        rst = 0;
        step();

        foreach (tbl[i]) begin
            launch(tbl[i].ub, tbl[i].rb, tbl[i].ws, tbl[i].nr, s0);
            wait_done(e);
            check_int($sformatf("latency_%0d", i), e - s0 + 1, tbl[i].lat);
            step();
            step();
        end

        // Abort during DRAIN, then a fresh tile two cycles later.
        dc0 = done_cnt;
        launch(10'h010, 10'h000, 2'd2, 6'd32, s0);
        while (ecnt < s0 + 49) step();
        abort = 1;
        step();
        abort = 0;
        check("abort_idle", dut_out(), 27'd0);
        step();
        start = 1;
        step();
        start = 0;
        wait_done(e);
        check_int("abort_restart_done", e - s0 + 1, 214);
        check_int("abort_done_count", done_cnt - dc0, 1);
        step();

        // Start pulse while running is ignored.
        dc0 = done_cnt;
        launch(10'h100, 10'h080, 2'd1, 6'd32, s0);
        while (ecnt < s0 + 9) step();
        start = 1;
        step();
        start = 0;
        wait_done(e);
        check_int("ignored_start_lat", e - s0 + 1, 162);
        step();
        step();
        check_int("ignored_start_count", done_cnt - dc0, 1);

        start = 1; abort = 1;
        step();
        check_int("start_abort_busy", int'(busy), 0);
        start = 0; abort = 0;
        step();

        // Asynchronous reset mid-STREAM.
        launch(10'h200, 10'h300, 2'd3, 6'd32, s0);
        while (ecnt < s0 + 10) step();
        #2 rst = 1;
        #1 check("async_reset", dut_out(), 27'd0);
        m_act = 0;
        step();
        rst = 0;
        step();

        // start held high: back-to-back tiles with a one-cycle gap.
        ub_base = 10'h010; res_base = 10'h000; weight_sel = 2'd2; num_rows = 6'd32;
        start = 1;
        step();
        s0 = ecnt;
        d1 = -1; d2 = -1;
        for (int k = 0; k < 400 && d2 < 0; k++) begin
            step();
            if (done) begin
                if (d1 < 0) d1 = ecnt - s0 + 1;
                else begin
                    d2 = ecnt - s0 + 1;
                    start = 0;
                end
            end
        end
        start = 0;
        check_int("b2b_done1", d1, 162);
        check_int("b2b_done2", d2, 325);
        abort = 1;
        step();
        abort = 0;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            start      = ($urandom % 24) == 0;
            abort      = ($urandom % 300) == 0;
            ub_base    = AS'($urandom);
            res_base   = AS'($urandom);
            weight_sel = AF'($urandom);
            num_rows   = RW'($urandom % 41);
            step();
        end
        start = 0; abort = 1;
        step();
        abort = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
